batch_sample_buffer: RTL and testbench

- Producer-side counterpart of the batch filter's sample-ordering checks: it generates the reordered sample streams and the batch indices that those checks consume.
- Stores incoming downsampled control-bit words into a rotating three-bank batch memory.
- Replays the most recently completed batch in reverse order as the lookahead stream.
- Replays the batch before that in forward order as the delayed forward stream.
- Exports the batch counters and cycle phase that sequence the forward/backward recursions.

---
 rtl/batch_buf_pkg.sv | 28 ++
 rtl/batch_bank_ram.sv | 26 ++
 rtl/batch_sample_buffer.sv | 134 +++++++++++++
 tb/tb_batch_sample_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/batch_buf_pkg.sv
// Shared sizing helpers, bank rotation and phase encoding for the batch sample buffer.
package batch_buf_pkg;

  localparam int unsigned DEF_N = 4;

  typedef logic [DEF_N-1:0] def_word_t;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_t;

  function automatic int unsigned ds_depth_f(input int unsigned depth, input int unsigned dsr);
    return (depth + dsr - 1) / dsr;
  endfunction

  function automatic int unsigned cw_f(input int unsigned ds);
    return (ds <= 1) ? 1 : $clog2(ds);
  endfunction

  function automatic logic [1:0] next_bank(input logic [1:0] c, input int unsigned k);
    int unsigned s;
    s = (32'(c) + k) % 3;
    return 2'(s);
  endfunction

endpackage

// File: rtl/batch_bank_ram.sv
// Simple dual-port RAM with registered read; one bank of the batch memory.
module batch_bank_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned W     = 4,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/batch_sample_buffer.sv
// Three-bank rotating batch store: writes the current batch, replays the previous
// batch reversed (lookahead) and the one before that forward (delayed forward).
module batch_sample_buffer import batch_buf_pkg::*; #(
  parameter  int unsigned N        = 4,
  parameter  int unsigned DSR      = 1,
  parameter  int unsigned depth    = 32,
  localparam int unsigned DS_DEPTH = ds_depth_f(depth, DSR),
  localparam int unsigned CW       = cw_f(DS_DEPTH),
  localparam int unsigned W        = N * DSR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_sample,
  output logic [W-1:0]  sample_lh,
  output logic [W-1:0]  sample_fd,
  output logic          out_valid,
  output logic [CW-1:0] bat_count,
  output logic [CW-1:0] bat_count_rev,
  output logic [1:0]    cycle,
  output logic          cycle_pulse
);

  localparam logic [CW-1:0] LAST = CW'(DS_DEPTH - 1);

  phase_t        r_state;
  phase_t        w_state_nxt;
  logic [CW-1:0] r_bat_count;
  logic [1:0]    r_primed;
  logic          r_out_valid;
  logic          r_cycle_pulse;
  logic          r_rd_ok;
  logic [1:0]    r_lh_sel;
  logic [1:0]    r_fd_sel;
  logic          w_wrap;
  logic [1:0]    w_wr_bank;
  logic [1:0]    w_lh_bank;
  logic [1:0]    w_fd_bank;
  logic [2:0]    w_we;
  logic [CW-1:0] w_raddr [3];
  logic [W-1:0]  w_rdata [3];

  assign w_wrap = in_valid && (r_bat_count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= PH0;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_wrap) begin
      unique case (r_state)
        PH0:     w_state_nxt = PH1;
        PH1:     w_state_nxt = PH2;
        default: w_state_nxt = PH0;
      endcase
    end
  end

  always_comb begin
    cycle     = 2'(r_state);
    w_wr_bank = 2'(r_state);
    w_lh_bank = next_bank(r_state, 2);
    w_fd_bank = next_bank(r_state, 1);
  end

  // Read-bank selects are captured with the read so the output mux stays aligned across a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bat_count   <= '0;
      r_primed      <= '0;
      r_out_valid   <= 1'b0;
      r_cycle_pulse <= 1'b0;
      r_rd_ok       <= 1'b0;
      r_lh_sel      <= '0;
      r_fd_sel      <= '0;
    end else begin
      r_out_valid   <= in_valid && (r_primed == 2'd2);
      r_cycle_pulse <= w_wrap;
      if (in_valid) begin
        r_bat_count <= w_wrap ? '0 : r_bat_count + CW'(1);
        r_lh_sel    <= w_lh_bank;
        r_fd_sel    <= w_fd_bank;
        if (r_primed == 2'd2) r_rd_ok <= 1'b1;
        if (w_wrap && (r_primed != 2'd2)) r_primed <= r_primed + 2'd1;
      end
    end
  end

  assign bat_count     = r_bat_count;
  assign bat_count_rev = LAST - r_bat_count;
  assign out_valid     = r_out_valid;
  assign cycle_pulse   = r_cycle_pulse;

  // Each non-write bank plays exactly one reader role per phase, so one read port suffices.
  for (genvar b = 0; b < 3; b++) begin : g_bank
    assign w_we[b]    = in_valid && (w_wr_bank == 2'(b));
    assign w_raddr[b] = (w_lh_bank == 2'(b)) ? bat_count_rev : r_bat_count;

    batch_bank_ram #(
      .DEPTH (DS_DEPTH),
      .W     (W),
      .AW    (CW)
    ) u_ram (
      .clk     (clk),
      .i_we    (w_we[b]),
      .i_waddr (r_bat_count),
      .i_wdata (in_sample),
      .i_re    (in_valid && (w_wr_bank != 2'(b))),
      .i_raddr (w_raddr[b]),
      .o_rdata (w_rdata[b])
    );
  end

  // Stale bank contents stay hidden until the first primed read has landed.
  always_comb begin
    sample_lh = '0;
    sample_fd = '0;
    if (r_rd_ok) begin
      case (r_lh_sel)
        2'd0:    sample_lh = w_rdata[0];
        2'd1:    sample_lh = w_rdata[1];
        default: sample_lh = w_rdata[2];
      endcase
      case (r_fd_sel)
        2'd0:    sample_fd = w_rdata[0];
        2'd1:    sample_fd = w_rdata[1];
        default: sample_fd = w_rdata[2];
      endcase
    end
  end

endmodule

// File: tb/tb_batch_sample_buffer.sv
// Scoreboarded bench for batch_sample_buffer over three parameter sets.
module tb_batch_sample_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_sample;

  always #5 clk = ~clk;

  logic [7:0]  d0_lh, d0_fd;
  logic        d0_ov, d0_pul;
  logic [2:0]  d0_cnt, d0_rev;
  logic [1:0]  d0_cyc;
  logic [11:0] d1_lh, d1_fd;
  logic        d1_ov, d1_pul;
  logic [1:0]  d1_cnt, d1_rev;
  logic [1:0]  d1_cyc;
  logic [7:0]  d2_lh, d2_fd;
  logic        d2_ov, d2_pul;
  logic [0:0]  d2_cnt, d2_rev;
  logic [1:0]  d2_cyc;

  batch_sample_buffer #(.N(8), .DSR(1), .depth(8)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample[7:0]),
    .sample_lh(d0_lh), .sample_fd(d0_fd), .out_valid(d0_ov), .bat_count(d0_cnt),
    .bat_count_rev(d0_rev), .cycle(d0_cyc), .cycle_pulse(d0_pul));

  batch_sample_buffer #(.N(4), .DSR(3), .depth(8)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
    .sample_lh(d1_lh), .sample_fd(d1_fd), .out_valid(d1_ov), .bat_count(d1_cnt),
    .bat_count_rev(d1_rev), .cycle(d1_cyc), .cycle_pulse(d1_pul));

  batch_sample_buffer #(.N(8), .DSR(1), .depth(1)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample[7:0]),
    .sample_lh(d2_lh), .sample_fd(d2_fd), .out_valid(d2_ov), .bat_count(d2_cnt),
    .bat_count_rev(d2_rev), .cycle(d2_cyc), .cycle_pulse(d2_pul));

  typedef struct {
    int sel; int base; int nwords; int gap;
    int first_k; int first_lh; int first_fd;
  } vec_t;

  typedef struct {
    bit ov; int lh; int fd; int cnt; int cyc; bit pul;
  } exp_t;

  exp_t sbq[$];
  int   DD[3] = '{8, 3, 1};
  int   WB[3] = '{8, 12, 8};
  int   n_tests = 0;
  int   n_fail  = 0;
  int   sel, k, m_base, m_lh, m_fd;
  int   first_k, first_lh, first_fd;

  function automatic int mask(input int v);
    return v & ((1 << WB[sel]) - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (inst %0d, word %0d): got %0d expected %0d", name, sel, k, act, exp);
    end
  endtask

  task automatic get_act(output exp_t a, output int rev);
    case (sel)
      0: begin a.ov = d0_ov; a.lh = int'(d0_lh); a.fd = int'(d0_fd); a.cnt = int'(d0_cnt);
               a.cyc = int'(d0_cyc); a.pul = d0_pul; rev = int'(d0_rev); end
      1: begin a.ov = d1_ov; a.lh = int'(d1_lh); a.fd = int'(d1_fd); a.cnt = int'(d1_cnt);
               a.cyc = int'(d1_cyc); a.pul = d1_pul; rev = int'(d1_rev); end
      default: begin a.ov = d2_ov; a.lh = int'(d2_lh); a.fd = int'(d2_fd); a.cnt = int'(d2_cnt);
               a.cyc = int'(d2_cyc); a.pul = d2_pul; rev = int'(d2_rev); end
    endcase
  endtask

  task automatic check_zero_state(input string tag);
    exp_t a; int rev;
    get_act(a, rev);
    chk({tag, "_out_valid"}, int'(a.ov), 0);
    chk({tag, "_sample_lh"}, a.lh, 0);
    chk({tag, "_sample_fd"}, a.fd, 0);
    chk({tag, "_bat_count"}, a.cnt, 0);
    chk({tag, "_bat_count_rev"}, rev, DD[sel] - 1);
    chk({tag, "_cycle"}, a.cyc, 0);
    chk({tag, "_cycle_pulse"}, int'(a.pul), 0);
  endtask

  task automatic model_clear();
    k = 0; m_lh = 0; m_fd = 0;
    first_k = -1; first_lh = -1; first_fd = -1;
    sbq.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sample = '0;
    rst = 1'b1;
    #2;
    check_zero_state("reset");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Called at a falling edge; one clock of stimulus, expectation queued, compared after the edge.
  task automatic step(input bit v, input int word);
    exp_t e, a; int rev, b, p, dd;
    dd = DD[sel];
    in_valid  = v;
    in_sample = v ? 12'(word) : 12'd0;
    e.ov = 1'b0; e.pul = 1'b0;
    if (v) begin
      b = k / dd; p = k % dd;
      if (b >= 2) begin
        m_lh = mask(m_base + (b - 1) * dd + (dd - 1 - p));
        m_fd = mask(m_base + (b - 2) * dd + p);
        e.ov = 1'b1;
      end
      k++;
      e.pul = (k % dd) == 0;
    end
    e.lh = m_lh; e.fd = m_fd; e.cnt = k % dd; e.cyc = (k / dd) % 3;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    get_act(a, rev);
    e = sbq.pop_front();
    chk("out_valid", int'(a.ov), int'(e.ov));
    chk("sample_lh", a.lh, e.lh);
    chk("sample_fd", a.fd, e.fd);
    chk("bat_count", a.cnt, e.cnt);
    chk("bat_count_rev", rev, dd - 1 - e.cnt);
    chk("cycle", a.cyc, e.cyc);
    chk("cycle_pulse", int'(a.pul), int'(e.pul));
    if (a.ov && first_k < 0) begin
      first_k = k - 1; first_lh = a.lh; first_fd = a.fd;
    end
  endtask

  task automatic run_phase(input int base, input int n, input int gap);
    m_base = base;
    for (int i = 0; i < n; i++) begin
      step(1'b1, base + i);
      for (int g = 0; g < gap; g++) step(1'b0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{sel: 0, base: 0, nwords: 24, gap: 0, first_k: 16, first_lh: 15, first_fd: 0};
    tbl[1] = '{sel: 0, base: 0, nwords: 24, gap: 3, first_k: 16, first_lh: 15, first_fd: 0};
    tbl[2] = '{sel: 1, base: 0, nwords: 9,  gap: 0, first_k: 6,  first_lh: 5,  first_fd: 0};
    tbl[3] = '{sel: 2, base: 5, nwords: 5,  gap: 0, first_k: 2,  first_lh: 6,  first_fd: 5};

    rst = 1'b1; in_valid = 1'b0; in_sample = '0;
    for (int t = 0; t < 4; t++) begin
      sel = tbl[t].sel;
      do_reset();
      run_phase(tbl[t].base, tbl[t].nwords, tbl[t].gap);
      chk("first_valid_word", first_k, tbl[t].first_k);
      chk("first_sample_lh", first_lh, tbl[t].first_lh);
      chk("first_sample_fd", first_fd, tbl[t].first_fd);
    end

    // Asynchronous reset in the middle of a batch, then a fresh ramp from 100.
    sel = 0;
    do_reset();
    run_phase(0, 13, 0);
    in_valid = 1'b1; in_sample = 12'd13;
    #2 rst = 1'b1;
    #1 check_zero_state("midreset");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    model_clear();
    run_phase(100, 24, 0);
    chk("midreset_first_valid_word", first_k, 16);
    chk("midreset_first_sample_lh", first_lh, 115);
    chk("midreset_first_sample_fd", first_fd, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
